box_anim_sched: RTL

Sequencer that owns the single plot port of the 160x120 VGA adapter and animates one solid rectangle: draw it, hold it for a programmable delay, erase it to black, step its position diagonally with edge bounce, and repeat. It sits between the top-level keys and switches and the VGA adapter's `x`/`y`/`colour`/`plot` inputs. It replaces the separate x/y counter, delay counter, datapath and control split with one scheduled engine.

---
 rtl/box_anim_sched.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/box_anim_sched.sv
// box_anim_sched: owns the VGA adapter plot port and animates one solid box.
// Cycle: DRAW the box, WAIT a programmable delay, ERASE it to black, MOVE it
// one pixel diagonally (bouncing off the screen edges), then DRAW again.
// Handshake: there is no valid/ready pair; plot is a write strobe and the
// adapter accepts one pixel on every clock edge where plot=1, no backpressure.
module box_anim_sched #(
  parameter int BOX_W  = 16,
  parameter int BOX_H  = 8,
  parameter int DELAY  = 12_499_999,
  parameter int SCR_W  = 160,
  parameter int SCR_H  = 120,
  parameter int X_INIT = 81,
  parameter int Y_INIT = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       go,
  input  logic       stop,
  input  logic [2:0] colour_in,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot,
  output logic       busy
);

  localparam int CW = $clog2(DELAY + 1);
  localparam logic [CW-1:0] DLY_LOAD = CW'(DELAY - 1);
  localparam logic [7:0] DX_LAST = 8'(BOX_W - 1);
  localparam logic [6:0] DY_LAST = 7'(BOX_H - 1);
  localparam logic [7:0] X_MAX   = 8'(SCR_W - BOX_W);
  localparam logic [6:0] Y_MAX   = 7'(SCR_H - BOX_H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW,
    S_WAIT,
    S_ERASE,
    S_MOVE
  } state_t;

  state_t        state;
  logic [7:0]    pos_x;
  logic [6:0]    pos_y;
  logic          dir_x;
  logic          dir_y;
  logic [7:0]    dx;
  logic [6:0]    dy;
  logic [CW-1:0] dly;
  logic [2:0]    col;
  logic          halt;

  logic          last_px;
  logic [7:0]    nx_pos_x;
  logic [6:0]    nx_pos_y;
  logic          nx_dir_x;
  logic          nx_dir_y;

  // Last pixel of the row-major box scan.
  assign last_px = (dx == DX_LAST) && (dy == DY_LAST);

  // Next box origin and direction with edge bounce; a full-width (or
  // full-height) box cannot move on that axis and stays pinned at 0.
  always_comb begin
    nx_pos_x = pos_x;
    nx_dir_x = dir_x;
    nx_pos_y = pos_y;
    nx_dir_y = dir_y;
    if (BOX_W == SCR_W) begin
      nx_pos_x = 8'd0;
    end else if (dir_x && (pos_x == X_MAX)) begin
      nx_dir_x = 1'b0;
      nx_pos_x = pos_x - 8'd1;
    end else if (!dir_x && (pos_x == 8'd0)) begin
      nx_dir_x = 1'b1;
      nx_pos_x = pos_x + 8'd1;
    end else begin
      nx_pos_x = dir_x ? pos_x + 8'd1 : pos_x - 8'd1;
    end
    if (BOX_H == SCR_H) begin
      nx_pos_y = 7'd0;
    end else if (dir_y && (pos_y == Y_MAX)) begin
      nx_dir_y = 1'b0;
      nx_pos_y = pos_y - 7'd1;
    end else if (!dir_y && (pos_y == 7'd0)) begin
      nx_dir_y = 1'b1;
      nx_pos_y = pos_y + 7'd1;
    end else begin
      nx_pos_y = dir_y ? pos_y + 7'd1 : pos_y - 7'd1;
    end
  end

  // Sequencer: state, scan counters, delay counter, position and colour.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      pos_x <= 8'(X_INIT);
      pos_y <= 7'(Y_INIT);
      dir_x <= 1'b1;
      dir_y <= 1'b1;
      dx    <= 8'd0;
      dy    <= 7'd0;
      dly   <= '0;
      col   <= 3'b000;
      halt  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            state <= S_DRAW;
            dx    <= 8'd0;
            dy    <= 7'd0;
            col   <= colour_in;
          end
        end
        S_DRAW, S_ERASE: begin
          if (last_px) begin
            dx <= 8'd0;
            dy <= 7'd0;
            if (state == S_DRAW) begin
              state <= S_WAIT;
              dly   <= DLY_LOAD;
            end else if (halt) begin
              state <= S_IDLE;
              halt  <= 1'b0;
            end else begin
              state <= S_MOVE;
            end
          end else if (dx == DX_LAST) begin
            dx <= 8'd0;
            dy <= dy + 7'd1;
          end else begin
            dx <= dx + 8'd1;
          end
        end
        S_WAIT: begin
          if (stop) halt <= 1'b1;
          if (dly == '0) begin
            state <= S_ERASE;
            dx    <= 8'd0;
            dy    <= 7'd0;
          end else begin
            dly <= dly - 1'b1;
          end
        end
        S_MOVE: begin
          pos_x <= nx_pos_x;
          pos_y <= nx_pos_y;
          dir_x <= nx_dir_x;
          dir_y <= nx_dir_y;
          col   <= colour_in;
          dx    <= 8'd0;
          dy    <= 7'd0;
          state <= S_DRAW;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Adapter outputs decoded from the registered state.
  assign x_out      = pos_x + dx;
  assign y_out      = pos_y + dy;
  assign plot       = (state == S_DRAW) || (state == S_ERASE);
  assign colour_out = (state == S_DRAW) ? col : 3'b000;
  assign busy       = (state != S_IDLE);

endmodule
